cp0_tlb_regs: RTL and testbench



---
 rtl/cp0_tlb_regs_pkg.sv | 33 +++
 rtl/cp0_tlb_regs_random_ctr.sv | 42 ++++
 rtl/cp0_tlb_regs.sv | 147 ++++++++++++++
 tb/tb_cp0_tlb_regs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_tlb_regs_pkg.sv
// Shared definitions for the CP0 MMU register file: register numbers, field ranges,
// write masks and default TLB geometry.
package cp0_tlb_regs_pkg;

    localparam int TLB_LINE_NUM_DEF      = 8;
    localparam int LOG2_TLB_LINE_NUM_DEF = 3;

    typedef enum logic [4:0] {
        CP0_INDEX    = 5'd0,
        CP0_RANDOM   = 5'd1,
        CP0_ENTRYLO0 = 5'd2,
        CP0_ENTRYLO1 = 5'd3,
        CP0_CONTEXT  = 5'd4,
        CP0_PAGEMASK = 5'd5,
        CP0_WIRED    = 5'd6,
        CP0_BADVADDR = 5'd8,
        CP0_ENTRYHI  = 5'd10
    } cp0_reg_e;

    localparam int VPN2_HI    = 31;
    localparam int VPN2_LO    = 13;
    localparam int PTEBASE_HI = 31;
    localparam int PTEBASE_LO = 23;
    localparam int BADVPN2_HI = 22;
    localparam int BADVPN2_LO = 4;

    // EntryLo layout: PFN[25:6] C[5:3] D[2] V[1] G[0]
    localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_WMASK  = 32'h03FF_FFFF;
    localparam logic [31:0] PAGEMASK_WMASK = 32'h01FF_E000;
    localparam logic [31:0] INDEX_P_MASK   = 32'h8000_0000;

endpackage

// File: rtl/cp0_tlb_regs_random_ctr.sv
// Random/Wired replacement counter: counts down from TLB_LINE_NUM-1 to Wired (or 0),
// wraps back to the top, and reloads whenever Wired is written.
module cp0_random_ctr
    import cp0_tlb_regs_pkg::*;
#(
    parameter int TLB_LINE_NUM      = TLB_LINE_NUM_DEF,
    parameter int LOG2_TLB_LINE_NUM = LOG2_TLB_LINE_NUM_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_step,
    input  logic                         i_wired_we,
    input  logic [LOG2_TLB_LINE_NUM-1:0] i_wired_wdata,
    output logic [LOG2_TLB_LINE_NUM-1:0] o_random,
    output logic [LOG2_TLB_LINE_NUM-1:0] o_wired
);

    localparam logic [LOG2_TLB_LINE_NUM-1:0] LAST = LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);

    logic [LOG2_TLB_LINE_NUM-1:0] r_random;
    logic [LOG2_TLB_LINE_NUM-1:0] r_wired;
    logic                         w_wrap;

    // Wired at the top entry pins Random there; otherwise wrap at Wired or at 0.
    assign w_wrap = (r_wired >= LAST) || (r_random == r_wired) || (r_random == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_random <= LAST;
            r_wired  <= '0;
        end else if (i_wired_we) begin
            r_wired  <= i_wired_wdata;
            r_random <= LAST;
        end else if (i_step) begin
            r_random <= w_wrap ? LAST : r_random - 1'b1;
        end
    end

    assign o_random = r_random;
    assign o_wired  = r_wired;

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 MMU register file feeding the TLB. Optional macro TLB_RANDOM_ON_TLBWR_EN makes
// Random step only on TLBWR cycles; by default Random steps every clock.
module cp0_tlb_regs
    import cp0_tlb_regs_pkg::*;
#(
    parameter int TLB_LINE_NUM      = TLB_LINE_NUM_DEF,
    parameter int LOG2_TLB_LINE_NUM = LOG2_TLB_LINE_NUM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0_en,
    input  logic [4:0]  cp0_addr,
    input  logic [2:0]  cp0_sel,
    input  logic [31:0] mtc0_wdata,
    output logic [31:0] mfc0_rdata,
    input  logic        tlbp_en,
    input  logic        tlbr_en,
    input  logic        tlbwr_en,
    input  logic [31:0] tlb_index_in,
    input  logic [31:0] tlb_entryhi_in,
    input  logic [31:0] tlb_pagemask_in,
    input  logic [31:0] tlb_entrylo0_in,
    input  logic [31:0] tlb_entrylo1_in,
    input  logic        exc_tlb,
    input  logic        exc_adr,
    input  logic [31:0] exc_badvaddr,
    output logic [31:0] EntryHi_out,
    output logic [31:0] PageMask_out,
    output logic [31:0] EntryLo0_out,
    output logic [31:0] EntryLo1_out,
    output logic [31:0] Index_out,
    output logic [31:0] Random_out
);

    localparam logic [31:0] INDEX_IDX_MASK = 32'(TLB_LINE_NUM - 1);

    logic [31:0] r_index;
    logic [31:0] r_entrylo0;
    logic [31:0] r_entrylo1;
    logic [31:0] r_context;
    logic [31:0] r_pagemask;
    logic [31:0] r_badvaddr;
    logic [31:0] r_entryhi;

    logic [LOG2_TLB_LINE_NUM-1:0] w_random;
    logic [LOG2_TLB_LINE_NUM-1:0] w_wired;
    logic [31:0] w_random32;
    logic [31:0] w_wired32;
    logic        w_exc;
    logic        w_tlb_op;
    logic        w_mtc0;
    logic        w_wired_we;
    logic        w_step;

    assign w_exc      = exc_tlb | exc_adr;
    assign w_tlb_op   = tlbr_en | tlbp_en;
    // Exception capture beats TLBR/TLBP, which beat MTC0.
    assign w_mtc0     = mtc0_en && (cp0_sel == 3'd0) && !w_exc && !w_tlb_op;
    assign w_wired_we = w_mtc0 && (cp0_addr == CP0_WIRED);

`ifdef TLB_RANDOM_ON_TLBWR_EN
    assign w_step = tlbwr_en;
`else
    // Free-running: tlbwr_en does not gate the step in this build.
    assign w_step = tlbwr_en | 1'b1;
`endif

    cp0_random_ctr #(
        .TLB_LINE_NUM      (TLB_LINE_NUM),
        .LOG2_TLB_LINE_NUM (LOG2_TLB_LINE_NUM)
    ) u_random_ctr (
        .clk           (clk),
        .rst           (rst),
        .i_step        (w_step),
        .i_wired_we    (w_wired_we),
        .i_wired_wdata (mtc0_wdata[LOG2_TLB_LINE_NUM-1:0]),
        .o_random      (w_random),
        .o_wired       (w_wired)
    );

    assign w_random32 = {{(32-LOG2_TLB_LINE_NUM){1'b0}}, w_random};
    assign w_wired32  = {{(32-LOG2_TLB_LINE_NUM){1'b0}}, w_wired};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index    <= '0;
            r_entrylo0 <= '0;
            r_entrylo1 <= '0;
            r_context  <= '0;
            r_pagemask <= '0;
            r_badvaddr <= '0;
            r_entryhi  <= '0;
        end else if (w_exc) begin
            r_badvaddr <= exc_badvaddr;
            if (exc_tlb) begin
                r_entryhi[VPN2_HI:VPN2_LO]       <= exc_badvaddr[VPN2_HI:VPN2_LO];
                r_context[BADVPN2_HI:BADVPN2_LO] <= exc_badvaddr[VPN2_HI:VPN2_LO];
            end
        end else if (w_tlb_op) begin
            if (tlbr_en) begin
                r_entryhi  <= tlb_entryhi_in & ENTRYHI_WMASK;
                r_pagemask <= tlb_pagemask_in & PAGEMASK_WMASK;
                r_entrylo0 <= tlb_entrylo0_in & ENTRYLO_WMASK;
                r_entrylo1 <= tlb_entrylo1_in & ENTRYLO_WMASK;
            end
            if (tlbp_en) begin
                r_index <= tlb_index_in & (INDEX_P_MASK | INDEX_IDX_MASK);
            end
        end else if (w_mtc0) begin
            case (cp0_addr)
                CP0_INDEX:    r_index    <= mtc0_wdata & INDEX_IDX_MASK;
                CP0_ENTRYLO0: r_entrylo0 <= mtc0_wdata & ENTRYLO_WMASK;
                CP0_ENTRYLO1: r_entrylo1 <= mtc0_wdata & ENTRYLO_WMASK;
                CP0_CONTEXT:  r_context[PTEBASE_HI:PTEBASE_LO] <= mtc0_wdata[PTEBASE_HI:PTEBASE_LO];
                CP0_PAGEMASK: r_pagemask <= mtc0_wdata & PAGEMASK_WMASK;
                CP0_ENTRYHI:  r_entryhi  <= mtc0_wdata & ENTRYHI_WMASK;
                default: ;
            endcase
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        if (cp0_sel == 3'd0) begin
            case (cp0_addr)
                CP0_INDEX:    mfc0_rdata = r_index;
                CP0_RANDOM:   mfc0_rdata = w_random32;
                CP0_ENTRYLO0: mfc0_rdata = r_entrylo0;
                CP0_ENTRYLO1: mfc0_rdata = r_entrylo1;
                CP0_CONTEXT:  mfc0_rdata = r_context;
                CP0_PAGEMASK: mfc0_rdata = r_pagemask;
                CP0_WIRED:    mfc0_rdata = w_wired32;
                CP0_BADVADDR: mfc0_rdata = r_badvaddr;
                CP0_ENTRYHI:  mfc0_rdata = r_entryhi;
                default:      mfc0_rdata = '0;
            endcase
        end
    end

    assign EntryHi_out  = r_entryhi;
    assign PageMask_out = r_pagemask;
    assign EntryLo0_out = r_entrylo0;
    assign EntryLo1_out = r_entrylo1;
    assign Index_out    = r_index;
    assign Random_out   = w_random32;

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Scoreboard bench for cp0_tlb_regs: driver pushes expected outputs from an abstract
// register model; a monitor pops and compares shortly after each falling edge.
module tb_cp0_tlb_regs;

    localparam int N = 8;
`ifdef TLB_RANDOM_ON_TLBWR_EN
    localparam bit FREE_RUN = 1'b0;
`else
    localparam bit FREE_RUN = 1'b1;
`endif

    logic        clk, rst;
    logic        mtc0_en, tlbp_en, tlbr_en, tlbwr_en, exc_tlb, exc_adr;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] mtc0_wdata, mfc0_rdata, tlb_index_in, tlb_entryhi_in, tlb_pagemask_in;
    logic [31:0] tlb_entrylo0_in, tlb_entrylo1_in, exc_badvaddr;
    logic [31:0] EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out;

    cp0_tlb_regs dut (
        .clk(clk), .rst(rst), .mtc0_en(mtc0_en), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel),
        .mtc0_wdata(mtc0_wdata), .mfc0_rdata(mfc0_rdata), .tlbp_en(tlbp_en), .tlbr_en(tlbr_en),
        .tlbwr_en(tlbwr_en), .tlb_index_in(tlb_index_in), .tlb_entryhi_in(tlb_entryhi_in),
        .tlb_pagemask_in(tlb_pagemask_in), .tlb_entrylo0_in(tlb_entrylo0_in),
        .tlb_entrylo1_in(tlb_entrylo1_in), .exc_tlb(exc_tlb), .exc_adr(exc_adr),
        .exc_badvaddr(exc_badvaddr), .EntryHi_out(EntryHi_out), .PageMask_out(PageMask_out),
        .EntryLo0_out(EntryLo0_out), .EntryLo1_out(EntryLo1_out), .Index_out(Index_out),
        .Random_out(Random_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst, we, p, rd, wr, et, ea;
        logic [4:0]  a;
        logic [2:0]  sel;
        logic [31:0] wd, idx_in, ehi_in, pm_in, lo0_in, lo1_in, bv;
    } stim_t;

    typedef struct {
        logic [31:0] rdata, ehi, pm, lo0, lo1, idx, rnd, k;
        bit          has_k;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Abstract architectural state.
    logic [31:0] m_index, m_lo0, m_lo1, m_ctx, m_pm, m_badv, m_ehi;
    int          m_random, m_wired;

    function automatic void model_reset();
        m_index = 0; m_lo0 = 0; m_lo1 = 0; m_ctx = 0; m_pm = 0; m_badv = 0; m_ehi = 0;
        m_random = N - 1;
        m_wired  = 0;
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] a, logic [2:0] sel);
        if (sel != 3'd0) return 32'd0;
        case (a)
            5'd0:    return m_index;
            5'd1:    return 32'(m_random);
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd4:    return m_ctx;
            5'd5:    return m_pm;
            5'd6:    return 32'(m_wired);
            5'd8:    return m_badv;
            5'd10:   return m_ehi;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step(stim_t s);
        int  old_wired = m_wired;
        bit  wired_written = 1'b0;
        bit  step = FREE_RUN ? 1'b1 : s.wr;
        if (s.et || s.ea) begin
            m_badv = s.bv;
            if (s.et) begin
                m_ehi = (s.bv & 32'hFFFFE000) | (m_ehi & 32'h000000FF);
                m_ctx = (m_ctx & 32'hFF800000) | ((s.bv >> 13) << 4);
            end
        end else if (s.rd || s.p) begin
            if (s.rd) begin
                m_ehi = s.ehi_in & 32'hFFFFE0FF;
                m_pm  = s.pm_in & 32'h01FFE000;
                m_lo0 = s.lo0_in & 32'h03FFFFFF;
                m_lo1 = s.lo1_in & 32'h03FFFFFF;
            end
            if (s.p) m_index = (s.idx_in & 32'h80000000) | (s.idx_in % N);
        end else if (s.we && s.sel == 3'd0) begin
            case (s.a)
                5'd0:  m_index = s.wd % N;
                5'd2:  m_lo0 = s.wd & 32'h03FFFFFF;
                5'd3:  m_lo1 = s.wd & 32'h03FFFFFF;
                5'd4:  m_ctx = (s.wd & 32'hFF800000) | (m_ctx & 32'h007FFFFF);
                5'd5:  m_pm = s.wd & 32'h01FFE000;
                5'd6:  begin m_wired = int'(s.wd % N); wired_written = 1'b1; end
                5'd10: m_ehi = s.wd & 32'hFFFFE0FF;
                default: ;
            endcase
        end
        if (wired_written) m_random = N - 1;
        else if (step) begin
            if (old_wired >= N - 1 || m_random == old_wired || m_random == 0) m_random = N - 1;
            else m_random = m_random - 1;
        end
    endfunction

    function automatic stim_t st_idle();
        stim_t s;
        s.rst = 0; s.we = 0; s.p = 0; s.rd = 0; s.wr = 0; s.et = 0; s.ea = 0;
        s.a = 0; s.sel = 0; s.wd = 0; s.idx_in = 0; s.ehi_in = 0; s.pm_in = 0;
        s.lo0_in = 0; s.lo1_in = 0; s.bv = 0;
        return s;
    endfunction

    function automatic stim_t st_rd(logic [4:0] a);
        stim_t s = st_idle();
        s.a = a;
        return s;
    endfunction

    function automatic stim_t st_wr(logic [4:0] a, logic [31:0] wd);
        stim_t s = st_idle();
        s.we = 1; s.a = a; s.wd = wd;
        return s;
    endfunction

    task automatic drive(stim_t s, bit has_k, logic [31:0] k);
        exp_t e;
        @(negedge clk);
        rst = s.rst; mtc0_en = s.we; cp0_addr = s.a; cp0_sel = s.sel; mtc0_wdata = s.wd;
        tlbp_en = s.p; tlbr_en = s.rd; tlbwr_en = s.wr; tlb_index_in = s.idx_in;
        tlb_entryhi_in = s.ehi_in; tlb_pagemask_in = s.pm_in; tlb_entrylo0_in = s.lo0_in;
        tlb_entrylo1_in = s.lo1_in; exc_tlb = s.et; exc_adr = s.ea; exc_badvaddr = s.bv;
        if (s.rst) model_reset();
        e.rdata = model_read(s.a, s.sel);
        e.ehi = m_ehi; e.pm = m_pm; e.lo0 = m_lo0; e.lo1 = m_lo1; e.idx = m_index;
        e.rnd = 32'(m_random); e.has_k = has_k; e.k = k;
        q.push_back(e);
        if (!s.rst) model_step(s);
    endtask

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp_v, $time);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mfc0_rdata",   mfc0_rdata,   e.rdata);
                chk("EntryHi_out",  EntryHi_out,  e.ehi);
                chk("PageMask_out", PageMask_out, e.pm);
                chk("EntryLo0_out", EntryLo0_out, e.lo0);
                chk("EntryLo1_out", EntryLo1_out, e.lo1);
                chk("Index_out",    Index_out,    e.idx);
                chk("Random_out",   Random_out,   e.rnd);
                if (e.has_k) chk("directed_read", mfc0_rdata, e.k);
            end
        end
    end

    initial begin : driver
        stim_t s;
        int    seq[8] = '{7, 6, 5, 4, 3, 2, 7, 6};
        int    guard;
        rst = 1'b1; mtc0_en = 0; cp0_addr = 0; cp0_sel = 0; mtc0_wdata = 0;
        tlbp_en = 0; tlbr_en = 0; tlbwr_en = 0; tlb_index_in = 0; tlb_entryhi_in = 0;
        tlb_pagemask_in = 0; tlb_entrylo0_in = 0; tlb_entrylo1_in = 0;
        exc_tlb = 0; exc_adr = 0; exc_badvaddr = 0;
        model_reset();

        s = st_rd(5'd1); s.rst = 1; drive(s, 1, 32'd7);
        s = st_rd(5'd0); s.rst = 1; drive(s, 1, 32'd0);
        drive(st_rd(5'd1), 1, 32'd7);
        drive(st_rd(5'd0), 1, 32'd0);
        drive(st_rd(5'd10), 1, 32'd0);

        drive(st_wr(5'd10, 32'hFFFFFFFF), 0, 0);
        drive(st_rd(5'd10), 1, 32'hFFFFE0FF);
        drive(st_wr(5'd2, 32'hFFFFFFFF), 0, 0);
        drive(st_rd(5'd2), 1, 32'h03FFFFFF);
        drive(st_wr(5'd5, 32'hFFFFFFFF), 0, 0);
        drive(st_rd(5'd5), 1, 32'h01FFE000);

        drive(st_wr(5'd4, 32'h80000000), 0, 0);
        drive(st_wr(5'd10, 32'h00000012), 0, 0);
        s = st_idle(); s.et = 1; s.bv = 32'h00403123; drive(s, 0, 0);
        drive(st_rd(5'd8), 1, 32'h00403123);
        drive(st_rd(5'd10), 1, 32'h00402012);
        drive(st_rd(5'd4), 1, 32'h80002010);

        s = st_idle(); s.p = 1; s.idx_in = 32'h80000000; drive(s, 0, 0);
        drive(st_rd(5'd0), 1, 32'h80000000);
        drive(st_wr(5'd0, 32'h00000003), 0, 0);
        drive(st_rd(5'd0), 1, 32'h00000003);

        s = st_wr(5'd10, 32'hAAAAAAAA); s.et = 1; s.bv = 32'h00004000; drive(s, 0, 0);
        drive(st_rd(5'd10), 1, 32'h00004012);
        s = st_idle(); s.rd = 1; s.ehi_in = 32'h00402112; drive(s, 0, 0);
        drive(st_rd(5'd10), 1, 32'h00402012);

        drive(st_wr(5'd6, 32'd2), 0, 0);
        for (int i = 0; i < 8; i++) drive(st_rd(5'd1), FREE_RUN, 32'(seq[i]));
        drive(st_rd(5'd1), FREE_RUN, 32'd5);
        drive(st_rd(5'd1), FREE_RUN, 32'd4);
        drive(st_wr(5'd6, 32'd5), 0, 0);
        drive(st_rd(5'd1), 1, 32'd7);
        drive(st_rd(5'd6), 1, 32'd5);

        s = st_wr(5'd10, 32'h12345678); s.rst = 1; drive(s, 1, 32'd0);
        drive(st_rd(5'd10), 1, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            s = st_idle();
            s.rst    = ($urandom % 400) == 0;
            s.we     = $urandom % 2;
            s.a      = 5'($urandom_range(0, 11));
            s.sel    = (($urandom % 8) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            s.wd     = (($urandom % 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            s.p      = ($urandom % 10) == 0;
            s.rd     = ($urandom % 10) == 0;
            s.wr     = ($urandom % 3) == 0;
            s.et     = ($urandom % 12) == 0;
            s.ea     = ($urandom % 12) == 0;
            s.idx_in = $urandom; s.ehi_in = $urandom; s.pm_in = $urandom;
            s.lo0_in = $urandom; s.lo1_in = $urandom; s.bv = $urandom;
            drive(s, 0, 0);
        end

        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
